fwd_ctrl: RTL and testbench

- Parametrised operand-forwarding and load-use hazard controller for the RV32I pipeline.
- Generalises the stage-2/stage-3 ASel compare:
  - tracks the destination registers of FWD_DEPTH in-flight instructions in an internal history shift register;
  - produces forward selects for both rs1 and rs2;
  - inserts load-use stall bubbles itself;
  - keeps a saturating stall-cycle counter.
- Sits beside the decode stage. It feeds the ALU A/B operand muxes and the PC/IF stall logic.

---
 rtl/fwd_ctrl.sv | 115 +++++++++++
 tb/tb_fwd_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the RV32I decode stage.
// Tracks in-flight destination registers and selects forwarding sources for rs1/rs2.
module fwd_ctrl #(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16,
    localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      dec_inst,
    input  logic             dec_valid,
    input  logic             hold,
    input  logic             flush,
    output logic [SELW-1:0]  fwd_sel_a,
    output logic [SELW-1:0]  fwd_sel_b,
    output logic             a_pc_sel,
    output logic             load_stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [FWD_DEPTH-1:0]      v_q, v_d;
    logic [FWD_DEPTH-1:0][4:0] rd_q, rd_d;
    logic [FWD_DEPTH-1:0]      ld_q, ld_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic       has_rd, has_rs1, has_rs2, is_load;
    logic       use_a, use_b, stall_a, stall_b;
    logic       unused_bits;

    assign unused_bits = ^{dec_inst[31:25], dec_inst[14:12]};

    always_comb begin
        opc     = dec_inst[6:0];
        rd      = dec_inst[11:7];
        rs1     = dec_inst[19:15];
        rs2     = dec_inst[24:20];
        has_rd  = (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != 5'd0);
        has_rs1 = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
        has_rs2 = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
        is_load = (opc == OPC_LOAD);
        a_pc_sel = (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_BRANCH);
        use_a   = dec_valid && has_rs1 && (rs1 != 5'd0);
        use_b   = dec_valid && has_rs2 && (rs2 != 5'd0);
    end

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        stall_a   = 1'b0;
        stall_b   = 1'b0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (use_a && v_q[i] && (rd_q[i] == rs1)) begin
                fwd_sel_a = SELW'(i + 1);
                stall_a   = ld_q[i] && (i < LOAD_LAT);
            end
            if (use_b && v_q[i] && (rd_q[i] == rs2)) begin
                fwd_sel_b = SELW'(i + 1);
                stall_b   = ld_q[i] && (i < LOAD_LAT);
            end
        end
        load_stall = !flush && (stall_a || stall_b);
    end

    // A stalled decode enters the history as a bubble so the load ages each cycle.
    always_comb begin
        v_d   = v_q;
        rd_d  = rd_q;
        ld_d  = ld_q;
        cnt_d = cnt_q;
        if (flush) begin
            v_d = '0;
        end else if (!hold) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                v_d[i]  = v_q[i-1];
                rd_d[i] = rd_q[i-1];
                ld_d[i] = ld_q[i-1];
            end
            v_d[0]  = dec_valid && has_rd && !load_stall;
            rd_d[0] = rd;
            ld_d[0] = is_load;
        end
        if (load_stall && !hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            rd_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            rd_q  <= rd_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed table-driven bench for fwd_ctrl (FWD_DEPTH=2, LOAD_LAT=1), with a
// narrow-counter instance sharing the stimulus to exercise saturation.
module tb_fwd_ctrl;

    localparam logic [31:0] I_ADD5  = 32'h002082B3; // add x5,x1,x2
    localparam logic [31:0] I_ADD6  = 32'h00328333; // add x6,x5,x3
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADDI5 = 32'h00128293; // addi x5,x5,1
    localparam logic [31:0] I_ADD55 = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] I_ADDX0 = 32'h00008013; // addi x0,x1,0
    localparam logic [31:0] I_USEX0 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] I_LUI   = 32'h000283B7; // lui x7 with bits[19:15]=5
    localparam logic [31:0] I_JAL   = 32'h000280EF; // jal x1 with bits[19:15]=5
    localparam logic [31:0] I_AUIPC = 32'h00000297; // auipc x5,0
    localparam logic [31:0] I_SW    = 32'h0050A023; // sw x5,0(x1)
    localparam logic [31:0] I_BEQ   = 32'h00328063; // beq x5,x3
    localparam logic [31:0] I_ADD66 = 32'h006303B3; // add x7,x6,x6

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dec_inst;
    logic        dec_valid, hold, flush;
    logic [1:0]  fwd_sel_a, fwd_sel_b, s_sel_a, s_sel_b;
    logic        a_pc_sel, load_stall, s_pc_sel, s_stall;
    logic [15:0] stall_count;
    logic [1:0]  s_count;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        logic        hold;
        logic        flush;
        logic        vld;
        logic [31:0] inst;
        int          sa;
        int          sb;
        int          pc;
        int          st;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fwd_ctrl #(.FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dec_inst(dec_inst), .dec_valid(dec_valid),
        .hold(hold), .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .a_pc_sel(a_pc_sel), .load_stall(load_stall), .stall_count(stall_count)
    );

    fwd_ctrl #(.FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .dec_inst(dec_inst), .dec_valid(dec_valid),
        .hold(hold), .flush(flush), .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b),
        .a_pc_sel(s_pc_sel), .load_stall(s_stall), .stall_count(s_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int h, input int f, input int v, input logic [31:0] inst,
                       input int sa, input int sb, input int pc, input int st, input int cnt);
        vec_t r;
        r.hold = (h != 0);
        r.flush = (f != 0);
        r.vld = (v != 0);
        r.inst = inst;
        r.sa = sa;
        r.sb = sb;
        r.pc = pc;
        r.st = st;
        r.cnt = cnt;
        vecs.push_back(r);
    endtask

    initial begin
        //  h  f  v  inst      sa sb pc st cnt
        add(0, 0, 1, I_ADD5,   0, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD6,   1, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD5,   0, 0, 0, 0, 0);
        add(0, 0, 0, I_ADD6,   0, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD6,   2, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD5,   0, 0, 0, 0, 0);
        add(0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
        add(0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD6,   0, 0, 0, 0, 0);
        add(0, 0, 1, I_LW5,    0, 0, 0, 0, 0);
        add(0, 0, 1, I_ADD6,   1, 0, 0, 1, 0);
        add(0, 0, 1, I_ADD6,   2, 0, 0, 0, 1);
        add(0, 0, 1, I_ADD5,   0, 0, 0, 0, 1);
        add(0, 0, 1, I_ADDI5,  1, 0, 0, 0, 1);
        add(0, 0, 1, I_ADD55,  1, 1, 0, 0, 1);
        add(0, 0, 1, I_ADDX0,  0, 0, 0, 0, 1);
        add(0, 0, 1, I_USEX0,  0, 0, 0, 0, 1);
        add(0, 0, 1, I_ADD5,   0, 0, 0, 0, 1);
        add(0, 0, 1, I_LUI,    0, 0, 0, 0, 1);
        add(0, 0, 1, I_JAL,    0, 0, 1, 0, 1);
        add(0, 0, 1, I_AUIPC,  0, 0, 1, 0, 1);
        add(0, 0, 1, I_SW,     2, 1, 0, 0, 1);
        add(0, 0, 1, I_BEQ,    2, 0, 1, 0, 1);
        add(0, 0, 1, I_LW5,    0, 0, 0, 0, 1);
        add(1, 0, 1, I_ADD6,   1, 0, 0, 1, 1);
        add(1, 0, 1, I_ADD6,   1, 0, 0, 1, 1);
        add(1, 0, 1, I_ADD6,   1, 0, 0, 1, 1);
        add(0, 1, 1, I_ADD6,   1, 0, 0, 0, 1);
        add(0, 0, 1, I_ADD55,  0, 0, 0, 0, 1);
        add(1, 1, 1, I_ADD66,  1, 1, 0, 0, 1);
        add(0, 0, 1, I_ADD66,  0, 0, 0, 0, 1);
        add(0, 0, 1, I_LW5,    0, 0, 0, 0, 1);
        add(0, 0, 1, I_SW,     0, 1, 0, 1, 1);
        add(0, 0, 1, I_SW,     0, 2, 0, 0, 2);
        add(0, 0, 1, I_LW5,    0, 0, 0, 0, 2);
        add(0, 0, 1, I_ADD6,   1, 0, 0, 1, 2);
        add(0, 0, 1, I_LW5,    0, 0, 0, 0, 3);
        add(0, 0, 1, I_ADD6,   1, 0, 0, 1, 3);
        add(0, 0, 1, I_ADD6,   2, 0, 0, 0, 4);

        rst_n = 1'b0;
        dec_inst = I_ADD6;
        dec_valid = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sel_a", int'(fwd_sel_a), 0);
        chk("rst.sel_b", int'(fwd_sel_b), 0);
        chk("rst.stall", int'(load_stall), 0);
        chk("rst.count", int'(stall_count), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            hold = vecs[i].hold;
            flush = vecs[i].flush;
            dec_valid = vecs[i].vld;
            dec_inst = vecs[i].inst;
            @(negedge clk);
            chk($sformatf("v%0d.sel_a", i), int'(fwd_sel_a), vecs[i].sa);
            chk($sformatf("v%0d.sel_b", i), int'(fwd_sel_b), vecs[i].sb);
            chk($sformatf("v%0d.pc_sel", i), int'(a_pc_sel), vecs[i].pc);
            chk($sformatf("v%0d.stall", i), int'(load_stall), vecs[i].st);
            chk($sformatf("v%0d.count", i), int'(stall_count), vecs[i].cnt);
            chk($sformatf("v%0d.sat_count", i), int'(s_count),
                (vecs[i].cnt > 3) ? 3 : vecs[i].cnt);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a cycle with a live producer in history.
        hold = 1'b0;
        flush = 1'b0;
        dec_valid = 1'b1;
        dec_inst = I_ADD66;
        #2;
        chk("mid.pre_sel_a", int'(fwd_sel_a), 1);
        chk("mid.pre_sel_b", int'(fwd_sel_b), 1);
        rst_n = 1'b0;
        #1;
        chk("mid.sel_a", int'(fwd_sel_a), 0);
        chk("mid.sel_b", int'(fwd_sel_b), 0);
        chk("mid.stall", int'(load_stall), 0);
        chk("mid.count", int'(stall_count), 0);
        chk("mid.sat_count", int'(s_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
